// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, one-deep output register with
// valid/ready handshake, redirect/flush handling and RUN/HALT/ERR control.
module inst_fetch #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] LAST_ADDR = 8'h48
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  addy,
  input  logic [31:0] inst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [7:0]  redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [7:0]  out_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [7:0]  out_pc_q, out_pc_d;
  logic        halted_q, halted_d;
  logic        misalign_err_q, misalign_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic load;
  logic handshake;

  assign load      = (!out_valid_q || out_ready) && !stall;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every _d starts as its _q so each path assigns each signal
    // and no latch can be inferred.
    state_d        = state_q;
    pc_d           = pc_q;
    out_valid_d    = out_valid_q;
    out_inst_d     = out_inst_q;
    out_pc_d       = out_pc_q;
    fetch_count_d  = fetch_count_q;

    // A handshake on a redirect edge still counts; the flush only drops
    // the register contents afterwards.
    if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if (redirect_en && (state_q != ERR)) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_addr;
      state_d     = (redirect_addr[1:0] == 2'b00) ? RUN : ERR;
    end else if ((state_q == RUN) && load) begin
      if (pc_q <= LAST_ADDR) begin
        out_inst_d  = inst;
        out_pc_d    = pc_q;
        out_valid_d = 1'b1;
        pc_d        = pc_q + 8'd4;  // 8-bit add wraps FC -> 00
      end else begin
        out_valid_d = 1'b0;
        state_d     = HALT;
      end
    end

    halted_d       = (state_d == HALT);
    misalign_err_d = (state_d == ERR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_inst_q     <= 32'h0;
      out_pc_q       <= 8'h0;
      halted_q       <= 1'b0;
      misalign_err_q <= 1'b0;
      fetch_count_q  <= 16'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      out_inst_q     <= out_inst_d;
      out_pc_q       <= out_pc_d;
      halted_q       <= halted_d;
      misalign_err_q <= misalign_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign addy         = pc_q;
  assign out_valid    = out_valid_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_err_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, directed halt/reset
// sequences and randomized traffic against a behavioural fetch model.
module tb_inst_fetch;

  localparam logic [7:0] RESET_PC  = 8'h00;
  localparam logic [7:0] LAST_ADDR = 8'h48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addy;
  logic [31:0] inst;
  logic        stall;
  logic        redirect_en;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];

  inst_fetch #(.RESET_PC(RESET_PC), .LAST_ADDR(LAST_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .addy(addy), .inst(inst), .stall(stall),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign inst = rom[addy[7:2]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pack(input logic v, input logic h, input logic e,
                                       input logic [7:0] a, input logic [7:0] opc,
                                       input logic [31:0] ins, input logic [15:0] cnt);
    return {29'b0, v, h, e, a, opc, ins, cnt};
  endfunction

  function automatic logic [95:0] observe();
    return pack(out_valid, halted, misalign_err, addy, out_pc, out_inst, fetch_count);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural model: what the fetch stage should present after the next edge.
  int          m_pc;
  bit          m_valid, m_halt, m_err;
  logic [31:0] m_inst;
  int          m_opc;
  int          m_count;

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 0; m_halt = 0; m_err = 0;
    m_inst = 32'h0; m_opc = 0; m_count = 0;
  endtask

  task automatic model_step(input bit st, input bit rdy, input bit ren, input logic [7:0] raddr);
    bit taken, can_load;
    taken    = m_valid && rdy;
    can_load = (!m_valid || rdy) && !st;
    if (taken && m_count < 65535) m_count = m_count + 1;
    if (ren && !m_err) begin
      m_valid = 0;
      m_pc    = raddr;
      m_halt  = 0;
      m_err   = (raddr % 4) != 0;
    end else if (!m_err && !m_halt && can_load) begin
      if (m_pc <= LAST_ADDR) begin
        m_inst  = rom[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 256;
      end else begin
        m_valid = 0;
        m_halt  = 1;
      end
    end
  endtask

  function automatic logic [95:0] model_view();
    return pack(m_valid, m_halt, m_err, 8'(m_pc), 8'(m_opc), m_inst, 16'(m_count));
  endfunction

  typedef struct {
    logic        st;
    logic        ren;
    logic [7:0]  raddr;
    logic        rdy;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_addy;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ren, input logic [7:0] raddr,
                              input logic rdy, input logic ev, input logic [7:0] epc,
                              input logic ee, input logic [15:0] ec, input logic [7:0] ea);
    vec_t v;
    v.st = st; v.ren = ren; v.raddr = raddr; v.rdy = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_err = ee; v.exp_cnt = ec; v.exp_addy = ea;
    return v;
  endfunction

  vec_t vecs [13];
  bit   found;
  bit   st_r, ren_r, rdy_r;
  logic [7:0] raddr_r;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0013 | (32'(i) << 16);
    rom[0]  = 32'h00450693;
    rom[1]  = 32'h00100713;
    rom[7]  = 32'hffc62883;
    rom[18] = 32'hfc1ff06f;

    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 8'h0; out_ready = 1'b0;
    #12;
    check("reset state", observe(), pack(0, 0, 0, RESET_PC, 8'h0, 32'h0, 16'h0));
    @(negedge clk);
    rst_n = 1'b1;

    //            st ren raddr  rdy  v  out_pc err cnt addy
    vecs[0]  = mk(0, 0, 8'h00, 1,   1, 8'h00, 0, 0, 8'h04);
    vecs[1]  = mk(0, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h04);
    vecs[2]  = mk(0, 0, 8'h00, 0,   1, 8'h00, 0, 0, 8'h04);
    vecs[3]  = mk(0, 0, 8'h00, 1,   1, 8'h04, 0, 1, 8'h08);
    vecs[4]  = mk(0, 1, 8'h1c, 1,   0, 8'h04, 0, 2, 8'h1c);
    vecs[5]  = mk(0, 0, 8'h00, 1,   1, 8'h1c, 0, 2, 8'h20);
    vecs[6]  = mk(0, 0, 8'h00, 1,   1, 8'h20, 0, 3, 8'h24);
    vecs[7]  = mk(1, 1, 8'h1c, 0,   0, 8'h20, 0, 3, 8'h1c);
    vecs[8]  = mk(1, 0, 8'h00, 1,   0, 8'h20, 0, 3, 8'h1c);
    vecs[9]  = mk(0, 0, 8'h00, 1,   1, 8'h1c, 0, 3, 8'h20);
    vecs[10] = mk(0, 1, 8'h1e, 1,   0, 8'h1c, 1, 4, 8'h1e);
    vecs[11] = mk(0, 1, 8'h00, 1,   0, 8'h1c, 1, 4, 8'h1e);
    vecs[12] = mk(0, 0, 8'h00, 1,   0, 8'h1c, 1, 4, 8'h1e);

    for (int i = 0; i < 13; i++) begin
      stall = vecs[i].st; redirect_en = vecs[i].ren;
      redirect_addr = vecs[i].raddr; out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d valid", i), 96'(out_valid), 96'(vecs[i].exp_valid));
      check($sformatf("vec%0d out_pc", i), 96'(out_pc), 96'(vecs[i].exp_pc));
      check($sformatf("vec%0d out_inst", i), 96'(out_inst), 96'(rom[vecs[i].exp_pc[7:2]]));
      check($sformatf("vec%0d flags", i), 96'({halted, misalign_err}), 96'({1'b0, vecs[i].exp_err}));
      check($sformatf("vec%0d count", i), 96'(fetch_count), 96'(vecs[i].exp_cnt));
      check($sformatf("vec%0d addy", i), 96'(addy), 96'(vecs[i].exp_addy));
    end
    stall = 0; redirect_en = 0; redirect_addr = 8'h0;

    // Run off the end of the program into HALT, then redirect back out.
    do_reset();
    out_ready = 1'b1;
    step();
    check("first fetch", 96'({out_valid, out_pc, out_inst}), 96'({1'b1, 8'h00, 32'h00450693}));
    step();
    check("second fetch", 96'({out_pc, out_inst, fetch_count}), 96'({8'h04, 32'h00100713, 16'd1}));
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid && out_pc == LAST_ADDR) found = 1;
      else step();
    end
    check("reach last addr", 96'(found), 96'(1));
    check("last inst", 96'(out_inst), 96'(32'hfc1ff06f));
    step();
    check("halt entry", 96'({out_valid, halted, misalign_err}), 96'({1'b0, 1'b1, 1'b0}));
    step();
    step();
    check("halt holds", 96'({out_valid, halted, addy, out_pc}), 96'({1'b0, 1'b1, 8'h4C, 8'h48}));
    redirect_en = 1'b1; redirect_addr = 8'h00;
    step();
    redirect_en = 1'b0;
    check("halt exit bubble", 96'({out_valid, halted}), 96'({1'b0, 1'b0}));
    step();
    check("halt exit fetch", 96'({out_valid, out_pc, out_inst}), 96'({1'b1, 8'h00, 32'h00450693}));
    step();

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    check("async reset", observe(), pack(0, 0, 0, RESET_PC, 8'h0, 32'h0, 16'h0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post reset fetch", 96'({out_valid, out_pc, fetch_count}), 96'({1'b1, 8'h00, 16'd0}));

    // Randomized traffic against the model, with periodic resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        stall = 0; redirect_en = 0; out_ready = 0;
        do_reset();
        model_reset();
      end
      st_r  = ($urandom_range(0, 3) == 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      ren_r = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) raddr_r = 8'($urandom);
      else raddr_r = 8'($urandom_range(0, 21) * 4);
      stall = st_r; out_ready = rdy_r; redirect_en = ren_r; redirect_addr = raddr_r;
      model_step(st_r, rdy_r, ren_r, raddr_r);
      step();
      check($sformatf("random cycle %0d", c), observe(), model_view());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-002 SHALL have parameter LAST_ADDR, default 8'h48, highest valid program address; fetch halts beyond it.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addy  output  8  fetch address to the instruction ROM, driven directly from the PC register.
REQ-006 SHALL have port inst  input  32  combinational ROM data for addy.
REQ-007 SHALL have port stall  input  1  freezes PC and output register when high.
REQ-008 SHALL have port redirect_en  input  1  branch/jump request from execute.
REQ-009 SHALL have port redirect_addr  input  8  redirect target byte address.
REQ-010 SHALL have port out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_ready  input  1  decode accepts the instruction this cycle.
REQ-012 SHALL have port out_inst  output  32  fetched instruction word.
REQ-013 SHALL have port out_pc  output  8  address out_inst was fetched from.
REQ-014 SHALL have port halted  output  1  high in state HALT.
REQ-015 SHALL have port misalign_err  output  1  high in state ERR.
REQ-016 SHALL have port fetch_count  output  16  count of completed out_valid&out_ready handshakes.

Function
REQ-017 SHALL implement states RUN, HALT, ERR; all outputs registered except addy (= pc register).
REQ-018 SHALL define load = (!out_valid | out_ready) & !stall.
REQ-019 In RUN with load and pc <= LAST_ADDR, SHALL capture out_inst<=inst, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-020 In RUN with load and pc > LAST_ADDR, SHALL set out_valid<=0 and go to HALT; pc holds.
REQ-021 With !load and no redirect, SHALL hold pc, out_inst, out_pc, out_valid unchanged (backpressure/stall).
REQ-022 pc+4 SHALL wrap modulo 256 (8'hFC -> 8'h00).
REQ-023 redirect_en SHALL take priority over stall, out_ready, and all states: out_valid<=0 (flush), pc<=redirect_addr.
REQ-024 On redirect with redirect_addr[1:0]==0, SHALL go to RUN (exits HALT).
REQ-025 On redirect with redirect_addr[1:0]!=0, SHALL go to ERR; pc still loads target; no further fetch.
REQ-026 ERR SHALL be sticky: only reset leaves ERR; redirects in ERR are ignored.
REQ-027 HALT SHALL keep out_valid=0 and pc unchanged until a redirect.
REQ-028 Redirect latency: out_valid low the cycle after the redirect edge, target instruction valid after the following edge (one bubble).
REQ-029 A handshake on the same edge as a redirect SHALL count in fetch_count; flushed instruction is not re-presented.
REQ-030 fetch_count SHALL increment on each out_valid&out_ready edge and saturate at 16'hFFFF.
REQ-031 out_inst, out_pc SHALL hold last value when out_valid=0.

Reset
REQ-032 While rst_n=0: pc=RESET_PC, state=RUN, out_valid=0, out_inst=32'h0, out_pc=8'h0, halted=0, misalign_err=0, fetch_count=0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL discard any pending instruction; first edge after release fetches RESET_PC.

Verification
REQ-034 Reset release, out_ready=1 -> out_pc 8'h00 inst 32'h00450693, then 8'h04 inst 32'h00100713, fetch_count increments each cycle.
REQ-035 out_ready=0 after first fetch -> out_inst 32'h00450693 held, addy stays 8'h04 until out_ready=1.
REQ-036 redirect_en=1, redirect_addr=8'h1c -> one bubble, then out_pc 8'h1c out_inst 32'hffc62883.
REQ-037 Run to 8'h48 (LAST_ADDR default) -> last out_inst 32'hfc1ff06f, then out_valid=0, halted=1; redirect to 8'h00 -> halted=0, 32'h00450693 delivered.
REQ-038 redirect_addr=8'h1e -> misalign_err=1, out_valid=0; later redirect to 8'h00 ignored; only rst_n=0 clears.
REQ-039 stall=1 with redirect_en=1 same cycle -> redirect wins; rst_n pulsed low mid-run -> all outputs at reset values immediately.
